// File: rtl/rf_pkg.sv
// Shared constants and encodings for the register-file write-back path.
//   RF_DATA_W   : register / write data width
//   RF_ADDR_W   : register address width
//   RF_NUM_REGS : number of architectural registers
//   RF_CNT_W    : width of each pending-producer counter in the scoreboard
//   req_idx_e   : write-back requester index (ALU = 0, MEM = 1)
package rf_pkg;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_ADDR_W   = 4;
    localparam int unsigned RF_NUM_REGS = 16;
    localparam int unsigned RF_CNT_W    = 2;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard.
// Each register owns a saturating-limit counter of reservations that have
// been issued but whose write-back has not yet been captured.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_mark_en/addr      : reserve a destination (accepted when o_mark_ready)
//   o_mark_ready        : counter of i_mark_addr is below its maximum
//   i_clr_en/addr       : write being captured by the register file this edge
//   i_rd_a, i_rd_b      : read-port addresses to check
//   o_hazard_a/b        : read-port address has a pending write
//   o_busy              : one bit per register, set while its counter != 0
module rf_scoreboard #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_mark_en,
    input  logic [ADDR_W-1:0]   i_mark_addr,
    output logic                o_mark_ready,
    input  logic                i_clr_en,
    input  logic [ADDR_W-1:0]   i_clr_addr,
    input  logic [ADDR_W-1:0]   i_rd_a,
    input  logic [ADDR_W-1:0]   i_rd_b,
    output logic                o_hazard_a,
    output logic                o_hazard_b,
    output logic [NUM_REGS-1:0] o_busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic                w_mark_acc;

    assign o_mark_ready = (r_cnt[i_mark_addr] != CNT_MAX);
    assign w_mark_acc   = i_mark_en && o_mark_ready;

    // A capture against an idle counter is legal and simply ignored,
    // so the decrement is masked at zero rather than wrapping.
    always_comb begin
        w_inc  = '0;
        w_dec  = '0;
        o_busy = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_inc[i]  = w_mark_acc && (i_mark_addr == ADDR_W'(i));
            w_dec[i]  = i_clr_en && (i_clr_addr == ADDR_W'(i)) && (r_cnt[i] != '0);
            o_busy[i] = (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    assign o_hazard_a = o_busy[i_rd_a];
    assign o_hazard_b = o_busy[i_rd_b];

endmodule

// File: rtl/rf_writeback_scheduler.sv
// Write-back scheduler for the 16x32 register file's single write port.
// Arbitrates round-robin between the ALU (requester 0) and the memory load
// path (requester 1), registers the winner onto the PC/C/Ld write port, and
// tracks outstanding destinations through rf_scoreboard for RAW hazards.
//   Clk, Reset              : clock, asynchronous active-high reset
//   req0_* / req1_*         : valid/addr/data in, ready out (ready = grant)
//   mark_en/addr, mark_ready: destination reservation from issue
//   rd_a, rd_b              : read addresses; hazard_a/hazard_b results
//   busy                    : per-register pending-write flags
//   rf_pc, rf_c, rf_ld      : register file write data, address, load enable
module rf_writeback_scheduler
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned CNT_W    = RF_CNT_W
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    input  logic                mark_en,
    input  logic [ADDR_W-1:0]   mark_addr,
    output logic                mark_ready,
    input  logic [ADDR_W-1:0]   rd_a,
    input  logic [ADDR_W-1:0]   rd_b,
    output logic                hazard_a,
    output logic                hazard_b,
    output logic [NUM_REGS-1:0] busy,
    output logic [DATA_W-1:0]   rf_pc,
    output logic [ADDR_W-1:0]   rf_c,
    output logic                rf_ld
);

    req_idx_e          r_ptr;
    req_idx_e          w_ptr_nxt;
    logic              w_gnt0;
    logic              w_gnt1;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    logic              r_ld;
    logic [ADDR_W-1:0] r_c;
    logic [DATA_W-1:0] r_pc;

    // Round-robin pointer only advances on contended cycles; a lone
    // requester wins without disturbing whose turn is next.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ptr <= REQ_ALU;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_ptr_nxt = r_ptr;
        if (req0_valid && req1_valid) begin
            if (r_ptr == REQ_ALU) begin
                w_gnt0    = 1'b1;
                w_ptr_nxt = REQ_MEM;
            end else begin
                w_gnt1    = 1'b1;
                w_ptr_nxt = REQ_ALU;
            end
        end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
        end
    end

    always_comb begin
        w_wr_addr = req0_addr;
        w_wr_data = req0_data;
        if (w_gnt1) begin
            w_wr_addr = req1_addr;
            w_wr_data = req1_data;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Output stage: one write per cycle, address/data hold when idle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ld <= 1'b0;
            r_c  <= '0;
            r_pc <= '0;
        end else begin
            r_ld <= w_gnt0 || w_gnt1;
            if (w_gnt0 || w_gnt1) begin
                r_c  <= w_wr_addr;
                r_pc <= w_wr_data;
            end
        end
    end

    assign rf_ld = r_ld;
    assign rf_c  = r_c;
    assign rf_pc = r_pc;

    // The scoreboard clears on the edge that the register file captures
    // the write, i.e. the edge that ends the rf_ld cycle.
    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_mark_en    (mark_en),
        .i_mark_addr  (mark_addr),
        .o_mark_ready (mark_ready),
        .i_clr_en     (r_ld),
        .i_clr_addr   (r_c),
        .i_rd_a       (rd_a),
        .i_rd_b       (rd_b),
        .o_hazard_a   (hazard_a),
        .o_hazard_b   (hazard_b),
        .o_busy       (busy)
    );

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Directed bench for rf_writeback_scheduler with a behavioural register file.
module tb_rf_writeback_scheduler;

    logic        Clk;
    logic        Reset;
    logic        req0_valid;
    logic [3:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        mark_en;
    logic [3:0]  mark_addr;
    logic        mark_ready;
    logic [3:0]  rd_a;
    logic [3:0]  rd_b;
    logic        hazard_a;
    logic        hazard_b;
    logic [15:0] busy;
    logic [31:0] rf_pc;
    logic [3:0]  rf_c;
    logic        rf_ld;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [31:0] rfm [16] = '{default: 32'h0};

    rf_writeback_scheduler #(
        .DATA_W   (32),
        .ADDR_W   (4),
        .NUM_REGS (16),
        .CNT_W    (2)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .mark_en    (mark_en),
        .mark_addr  (mark_addr),
        .mark_ready (mark_ready),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .busy       (busy),
        .rf_pc      (rf_pc),
        .rf_c       (rf_c),
        .rf_ld      (rf_ld)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Register file behind the write port.
    always @(posedge Clk) begin
        if (rf_ld) rfm[rf_c] <= rf_pc;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        mark_en = 1'b0; mark_addr = '0;
        rd_a = '0; rd_b = '0;

        // Reset state
        #12;
        chk("rst_ld", 32'(rf_ld), 32'h0);
        chk("rst_c", 32'(rf_c), 32'h0);
        chk("rst_pc", rf_pc, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        step();
        Reset = 1'b0;

        // Single ALU request to R10
        req0_valid = 1'b1; req0_addr = 4'hA; req0_data = 32'd939;
        #1;
        chk("t1_rdy0", 32'(req0_ready), 32'h1);
        chk("t1_rdy1", 32'(req1_ready), 32'h0);
        step();
        req0_valid = 1'b0;
        chk("t1_ld", 32'(rf_ld), 32'h1);
        chk("t1_c", 32'(rf_c), 32'd10);
        chk("t1_pc", rf_pc, 32'd939);
        step();
        chk("t1_ld_off", 32'(rf_ld), 32'h0);
        chk("t1_c_hold", 32'(rf_c), 32'd10);
        chk("t1_pc_hold", rf_pc, 32'd939);
        chk("t1_r10", rfm[10], 32'd939);

        // Both requesters contend every cycle: alternate 0,1,0,1
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 32'h22;
        #1;
        chk("t2_rdy0_a", 32'(req0_ready), 32'h1);
        chk("t2_rdy1_a", 32'(req1_ready), 32'h0);
        step();
        chk("t2_c0", 32'(rf_c), 32'd1);
        chk("t2_ld0", 32'(rf_ld), 32'h1);
        chk("t2_rdy1_b", 32'(req1_ready), 32'h1);
        step();
        chk("t2_c1", 32'(rf_c), 32'd2);
        chk("t2_ld1", 32'(rf_ld), 32'h1);
        chk("t2_pc1", rf_pc, 32'h22);
        step();
        chk("t2_c2", 32'(rf_c), 32'd1);
        chk("t2_ld2", 32'(rf_ld), 32'h1);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t2_c3", 32'(rf_c), 32'd2);
        chk("t2_ld3", 32'(rf_ld), 32'h1);
        step();
        chk("t2_ld_off", 32'(rf_ld), 32'h0);

        // Reserve R5, hazard tracks the write-back
        mark_en = 1'b1; mark_addr = 4'd5; rd_a = 4'd5;
        #1;
        chk("t3_mrdy", 32'(mark_ready), 32'h1);
        chk("t3_haz_pre", 32'(hazard_a), 32'h0);
        step();
        mark_en = 1'b0;
        chk("t3_haz_mark", 32'(hazard_a), 32'h1);
        chk("t3_busy", 32'(busy), 32'h0020);
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 32'h55;
        step();
        req0_valid = 1'b0;
        chk("t3_ld", 32'(rf_ld), 32'h1);
        chk("t3_haz_ld", 32'(hazard_a), 32'h1);
        step();
        chk("t3_haz_clr", 32'(hazard_a), 32'h0);
        chk("t3_busy_clr", 32'(busy), 32'h0);
        chk("t3_r5", rfm[5], 32'h55);

        // Reserve R3 up to the counter limit
        mark_en = 1'b1; mark_addr = 4'd3; rd_b = 4'd3;
        step();
        chk("t4_mrdy1", 32'(mark_ready), 32'h1);
        step();
        chk("t4_mrdy2", 32'(mark_ready), 32'h1);
        step();
        chk("t4_mrdy3", 32'(mark_ready), 32'h0);
        chk("t4_haz_b", 32'(hazard_b), 32'h1);
        step();
        mark_en = 1'b0;
        chk("t4_busy_sat", 32'(busy), 32'h0008);
        chk("t4_mrdy_sat", 32'(mark_ready), 32'h0);
        req1_valid = 1'b1; req1_addr = 4'd3; req1_data = 32'h33;
        step();
        chk("t4_busy_a", 32'(busy[3]), 32'h1);
        step();
        chk("t4_busy_b", 32'(busy[3]), 32'h1);
        chk("t4_mrdy_b", 32'(mark_ready), 32'h1);
        step();
        req1_valid = 1'b0;
        chk("t4_busy_c", 32'(busy[3]), 32'h1);
        chk("t4_ld_c", 32'(rf_ld), 32'h1);
        step();
        chk("t4_busy_d", 32'(busy[3]), 32'h0);
        chk("t4_haz_b_clr", 32'(hazard_b), 32'h0);

        // Same-cycle mark and capture on R7
        mark_en = 1'b1; mark_addr = 4'd7;
        step();
        mark_en = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 32'h77;
        step();
        req0_valid = 1'b0;
        chk("t5_ld7", 32'(rf_ld), 32'h1);
        mark_en = 1'b1; mark_addr = 4'd7;
        step();
        mark_en = 1'b0;
        chk("t5_busy_same", 32'(busy), 32'h0080);
        req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 32'h78;
        step();
        req0_valid = 1'b0;
        step();
        chk("t5_busy_7clr", 32'(busy), 32'h0);
        // Write-back to unreserved R8
        req0_valid = 1'b1; req0_addr = 4'd8; req0_data = 32'h88;
        step();
        req0_valid = 1'b0;
        chk("t5_ld8", 32'(rf_ld), 32'h1);
        step();
        mark_addr = 4'd8;
        #1;
        chk("t5_busy8", 32'(busy), 32'h0);
        chk("t5_mrdy8", 32'(mark_ready), 32'h1);

        // Asynchronous reset while a write is in the output stage
        mark_en = 1'b1; mark_addr = 4'd9; rd_a = 4'd9; rd_b = 4'd9;
        step();
        mark_en = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd12; req0_data = 32'hC0;
        req1_valid = 1'b1; req1_addr = 4'd9;  req1_data = 32'h99;
        step();
        chk("t6_ld_pre", 32'(rf_ld), 32'h1);
        chk("t6_haz_pre", 32'(hazard_a), 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        chk("t6_ld_rst", 32'(rf_ld), 32'h0);
        chk("t6_busy_rst", 32'(busy), 32'h0);
        chk("t6_haza_rst", 32'(hazard_a), 32'h0);
        chk("t6_hazb_rst", 32'(hazard_b), 32'h0);
        step();
        chk("t6_r12_kept", rfm[12], 32'h0);
        Reset = 1'b0;
        #1;
        chk("t6_rdy0", 32'(req0_ready), 32'h1);
        chk("t6_rdy1", 32'(req1_ready), 32'h0);
        step();
        chk("t6_c", 32'(rf_c), 32'd12);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t6_c_next", 32'(rf_c), 32'd9);
        chk("t6_r12", rfm[12], 32'hC0);
        step();
        chk("t6_r9", rfm[9], 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
